vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised raster timing generator for the video output path. It produces pixel and line counts, horizontal and vertical sync, blanking, line and frame strobes, and a frame counter for any display mode set by parameters. Sync polarity is configurable, and a pixel-clock enable is provided. A configurable delay on the sync and blank outputs aligns them with a downstream pixel pipeline of known latency. Pixel-generation logic consumes the counts; the sync and blank outputs drive the display connector.

## Interface
Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BP, 160, horizontal back porch (pixels); H_TOTAL = sum of all four H parameters
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines); V_TOTAL = sum of all four V parameters
- HSYNC_POL, 0, active level of hsync_out (0 = active-low)
- VSYNC_POL, 0, active level of vsync_out
- SYNC_DELAY, 0, extra register stages on hsync_out, vsync_out and blank_out (0..15)
- HCOUNT_W, 12, hcount width; must satisfy H_TOTAL ≤ 2^HCOUNT_W
- VCOUNT_W, 11, vcount width; must satisfy V_TOTAL ≤ 2^VCOUNT_W
- FRAME_W, 8, frame counter width

Ports:
- vclock_in, in, 1, pixel clock
- reset_in, in, 1, synchronous active-high reset
- pixel_en_in, in, 1, clock enable; all state advances only when high
- hcount_out, out, HCOUNT_W, pixel index in current line
- vcount_out, out, VCOUNT_W, line index in current frame
- hsync_out, out, 1, horizontal sync, polarity per HSYNC_POL
- vsync_out, out, 1, vertical sync, polarity per VSYNC_POL
- blank_out, out, 1, high outside the visible area
- line_start_out, out, 1, high while hcount_out == 0
- frame_start_out, out, 1, high while hcount_out == 0 and vcount_out == 0
- frame_count_out, out, FRAME_W, completed-frame count, wraps modulo 2^FRAME_W

## Operation
- All outputs are registered. There are no combinational input-to-output paths.
- Counters (h, v):
  - h increments when pixel_en_in is high.
  - At h == H_TOTAL-1, h goes to 0 and v increments.
  - At h == H_TOTAL-1 and v == V_TOTAL-1, both counters go to 0 and frame_count increments. The 2^FRAME_W-1 → 0 wrap is silent.
- Raw signals, computed from the current (h, v):
  - blank = (h ≥ H_ACTIVE) | (v ≥ V_ACTIVE).
  - hsync active iff H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - vsync active iff V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, applied to whole lines from h = 0.
- Outputs with SYNC_DELAY = 0: hcount_out, vcount_out, strobes, frame_count_out and the raw sync/blank values all describe the same pixel in the same cycle.
- Outputs with SYNC_DELAY = D > 0:
  - hsync_out, vsync_out and blank_out pass through a D-stage shift register that advances only on enabled cycles.
  - They therefore describe the pixel shown on hcount_out D enabled cycles earlier.
  - Counts, strobes and frame_count_out are not delayed.
- Enable low: every register holds, including the delay stages.
- Reset:
  - Dominates pixel_en_in and takes effect at the next edge, mid-line or mid-frame.
  - Reset values: hcount_out = 0, vcount_out = 0, frame_count_out = 0, line_start_out = 1, frame_start_out = 1.
  - hsync_out and vsync_out go to their inactive levels.
  - blank_out = 0 when D = 0 (pixel 0,0 is visible). When D > 0 all delay stages reset to blank = 1 with syncs inactive, so blank_out stays 1 for the first D enabled cycles.
- Parameter legality, checked by elaboration assertions:
  - Every timing parameter ≥ 1.
  - H_TOTAL and V_TOTAL fit their count widths.
  - SYNC_DELAY ≤ 15.

## Timing
- Counter latency: one cycle from an enabled edge to the updated count.
- Line period: H_TOTAL enabled cycles. Frame period: H_TOTAL·V_TOTAL enabled cycles.
- The hsync pulse is exactly H_SYNC enabled cycles wide. The vsync pulse is exactly V_SYNC·H_TOTAL enabled cycles wide.
- frame_count_out updates in the same cycle that frame_start_out rises, except after reset, where the count is 0 and the strobe is already high.
- line_start_out and frame_start_out are level-valid for one enabled cycle. They stay high while pixel_en_in is low.

## Test plan
Test parameters unless stated: H = 8/2/3/3 (H_TOTAL 16), V = 4/1/2/1 (V_TOTAL 8), SYNC_DELAY 0, polarities 0.
- Reset then enable constant high → hcount_out sequence 0..15,0; vcount_out increments at each hcount wrap; vcount_out wraps 7→0 after 128 cycles; frame_count_out = 1 at the second frame_start_out.
- Same run → hsync_out low exactly at hcount_out 10,11,12; blank_out high at hcount_out 8..15 and on all of lines 4..7; vsync_out low for all 32 pixels of lines 5 and 6.
- HSYNC_POL = 1, VSYNC_POL = 1 → same windows with high-active pulses; idle level is 0 after reset.
- SYNC_DELAY = 3 → blank_out = 1 for 3 cycles after reset; hsync_out low at hcount_out 13,14,15; counts are identical to the first scenario.
- pixel_en_in toggling 1,0,0,1 repeatedly → every output holds during enable-low cycles; hsync width stays 3 enabled cycles; with SYNC_DELAY = 3, alignment is preserved in enabled cycles.
- Reset asserted at hcount 6 / vcount 5 with enable low, and separately with FRAME_W = 2 over 5 frames → all outputs return to reset values next edge; frame_count_out sequence is 0,1,2,3,0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, sync and blank
// generation, line/frame strobes and a frame counter, all registered.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int H_ACTIVE   = 1024,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 136,
  parameter int H_BP       = 160,
  parameter int V_ACTIVE   = 768,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 29,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int SYNC_DELAY = 0,
  parameter int HCOUNT_W   = 12,
  parameter int VCOUNT_W   = 11,
  parameter int FRAME_W    = 8
) (
  input  logic                vclock_in,
  input  logic                reset_in,
  input  logic                pixel_en_in,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                blank_out,
  output logic                line_start_out,
  output logic                frame_start_out,
  output logic [FRAME_W-1:0]  frame_count_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HCOUNT_W-1:0] H_LAST = HCOUNT_W'(H_TOTAL - 1);
  localparam logic [HCOUNT_W-1:0] H_VIS  = HCOUNT_W'(H_ACTIVE);
  localparam logic [HCOUNT_W-1:0] HS_BEG = HCOUNT_W'(H_ACTIVE + H_FP);
  localparam logic [HCOUNT_W-1:0] HS_END = HCOUNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCOUNT_W-1:0] V_LAST = VCOUNT_W'(V_TOTAL - 1);
  localparam logic [VCOUNT_W-1:0] V_VIS  = VCOUNT_W'(V_ACTIVE);
  localparam logic [VCOUNT_W-1:0] VS_BEG = VCOUNT_W'(V_ACTIVE + V_FP);
  localparam logic [VCOUNT_W-1:0] VS_END = VCOUNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $error("vga_timing_gen: every timing parameter must be at least 1");
  end
  if (longint'(H_TOTAL) > (longint'(1) << HCOUNT_W)) begin : g_bad_hw
    $error("vga_timing_gen: H_TOTAL does not fit in HCOUNT_W bits");
  end
  if (longint'(V_TOTAL) > (longint'(1) << VCOUNT_W)) begin : g_bad_vw
    $error("vga_timing_gen: V_TOTAL does not fit in VCOUNT_W bits");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 15) begin : g_bad_dly
    $error("vga_timing_gen: SYNC_DELAY must be in 0..15");
  end

  function automatic logic blank_of(input logic [HCOUNT_W-1:0] h,
                                    input logic [VCOUNT_W-1:0] v);
    return (h >= H_VIS) || (v >= V_VIS);
  endfunction

  function automatic logic hsync_lvl(input logic [HCOUNT_W-1:0] h);
    return ((h >= HS_BEG) && (h < HS_END)) ? HS_ON : ~HS_ON;
  endfunction

  function automatic logic vsync_lvl(input logic [VCOUNT_W-1:0] v);
    return ((v >= VS_BEG) && (v < VS_END)) ? VS_ON : ~VS_ON;
  endfunction

  logic [HCOUNT_W-1:0] h_nxt;
  logic [VCOUNT_W-1:0] v_nxt;
  logic [FRAME_W-1:0]  frame_nxt;

  always_comb begin
    h_nxt     = hcount_out + 1'b1;
    v_nxt     = vcount_out;
    frame_nxt = frame_count_out;
    if (hcount_out == H_LAST) begin
      h_nxt = '0;
      if (vcount_out == V_LAST) begin
        v_nxt     = '0;
        frame_nxt = frame_count_out + 1'b1;
      end else begin
        v_nxt = vcount_out + 1'b1;
      end
    end
  end

  // Stage p0: counts, strobes and raw sync/blank for the same pixel.
  // Raw values are derived from the next counts so they land with them.
  logic blank_p0, hsync_p0, vsync_p0;

  always_ff @(posedge vclock_in) begin
    if (reset_in) begin
      hcount_out      <= '0;
      vcount_out      <= '0;
      frame_count_out <= '0;
      line_start_out  <= 1'b1;
      frame_start_out <= 1'b1;
      blank_p0        <= 1'b0;
      hsync_p0        <= ~HS_ON;
      vsync_p0        <= ~VS_ON;
    end else if (pixel_en_in) begin
      hcount_out      <= h_nxt;
      vcount_out      <= v_nxt;
      frame_count_out <= frame_nxt;
      line_start_out  <= (h_nxt == '0);
      frame_start_out <= (h_nxt == '0) && (v_nxt == '0);
      blank_p0        <= blank_of(h_nxt, v_nxt);
      hsync_p0        <= hsync_lvl(h_nxt);
      vsync_p0        <= vsync_lvl(v_nxt);
    end
  end

  // Stages p1..pD: enable-gated delay line for {blank, vsync, hsync}.
  if (SYNC_DELAY == 0) begin : g_nodly
    assign blank_out = blank_p0;
    assign hsync_out = hsync_p0;
    assign vsync_out = vsync_p0;
  end else begin : g_dly
    logic [2:0] dly_p1 [SYNC_DELAY];

    always_ff @(posedge vclock_in) begin
      if (reset_in) begin
        for (int i = 0; i < SYNC_DELAY; i++) begin
          dly_p1[i] <= {1'b1, ~VS_ON, ~HS_ON};
        end
      end else if (pixel_en_in) begin
        dly_p1[0] <= {blank_p0, vsync_p0, hsync_p0};
        for (int i = 1; i < SYNC_DELAY; i++) begin
          dly_p1[i] <= dly_p1[i-1];
        end
      end
    end

    assign {blank_out, vsync_out, hsync_out} = dly_p1[SYNC_DELAY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a small 16x8 raster in four parameter
// variants (baseline, positive syncs, 3-stage sync delay, 2-bit frame count).
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] a_h, b_h, c_h, e_h;
  logic [2:0] a_v, b_v, c_v, e_v;
  logic a_hs, b_hs, c_hs, e_hs, a_vs, b_vs, c_vs, e_vs;
  logic a_bl, b_bl, c_bl, e_bl, a_ls, b_ls, c_ls, e_ls, a_fs, b_fs, c_fs, e_fs;
  logic [7:0] a_fc, b_fc, c_fc;
  logic [1:0] e_fc;

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HSYNC_POL(0), .VSYNC_POL(0),
    .SYNC_DELAY(0), .HCOUNT_W(4), .VCOUNT_W(3), .FRAME_W(8)) u_a (
    .vclock_in(clk), .reset_in(rst), .pixel_en_in(en), .hcount_out(a_h),
    .vcount_out(a_v), .hsync_out(a_hs), .vsync_out(a_vs), .blank_out(a_bl),
    .line_start_out(a_ls), .frame_start_out(a_fs), .frame_count_out(a_fc));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HSYNC_POL(1), .VSYNC_POL(1),
    .SYNC_DELAY(0), .HCOUNT_W(4), .VCOUNT_W(3), .FRAME_W(8)) u_b (
    .vclock_in(clk), .reset_in(rst), .pixel_en_in(en), .hcount_out(b_h),
    .vcount_out(b_v), .hsync_out(b_hs), .vsync_out(b_vs), .blank_out(b_bl),
    .line_start_out(b_ls), .frame_start_out(b_fs), .frame_count_out(b_fc));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HSYNC_POL(0), .VSYNC_POL(0),
    .SYNC_DELAY(3), .HCOUNT_W(4), .VCOUNT_W(3), .FRAME_W(8)) u_c (
    .vclock_in(clk), .reset_in(rst), .pixel_en_in(en), .hcount_out(c_h),
    .vcount_out(c_v), .hsync_out(c_hs), .vsync_out(c_vs), .blank_out(c_bl),
    .line_start_out(c_ls), .frame_start_out(c_fs), .frame_count_out(c_fc));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HSYNC_POL(0), .VSYNC_POL(0),
    .SYNC_DELAY(0), .HCOUNT_W(4), .VCOUNT_W(3), .FRAME_W(2)) u_e (
    .vclock_in(clk), .reset_in(rst), .pixel_en_in(en), .hcount_out(e_h),
    .vcount_out(e_v), .hsync_out(e_hs), .vsync_out(e_vs), .blank_out(e_bl),
    .line_start_out(e_ls), .frame_start_out(e_fs), .frame_count_out(e_fc));

  typedef struct {
    logic rst; logic en;
    int   h;   int   v;
    logic hs;  logic vs; logic bl; logic ls; logic fs;
    int   fc;
  } vec_t;

  vec_t tbl [22];
  int n_cmp = 0;
  int n_bad = 0;
  int n     = 0;   // enabled edges since the last reset
  int fc_seq [8];
  int n_seq = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0d, need %0d", nm, $time, act, exp);
    end
  endtask

  task automatic tick(input logic r, input logic e);
    rst = r;
    en  = e;
    @(posedge clk);
    #2;
    if (r) n = 0;
    else if (e) n++;
  endtask

  function automatic int px_h(input int m); return m % 16;       endfunction
  function automatic int px_v(input int m); return (m / 16) % 8; endfunction
  function automatic logic hs_act(input int m);
    return (px_h(m) >= 10) && (px_h(m) <= 12);
  endfunction
  function automatic logic vs_act(input int m);
    return (px_v(m) == 5) || (px_v(m) == 6);
  endfunction
  function automatic logic bl_exp(input int m);
    return (px_h(m) >= 8) || (px_v(m) >= 4);
  endfunction

  task automatic check_model();
    int h, v;
    h = px_h(n);
    v = px_v(n);
    chk("a_hcount", a_h, h);
    chk("a_vcount", a_v, v);
    chk("a_frame", a_fc, (n / 128) % 256);
    chk("a_hsync", a_hs, !hs_act(n));
    chk("a_vsync", a_vs, !vs_act(n));
    chk("a_blank", a_bl, bl_exp(n));
    chk("a_line_start", a_ls, h == 0);
    chk("a_frame_start", a_fs, (h == 0) && (v == 0));
    chk("b_hsync", b_hs, hs_act(n));
    chk("b_vsync", b_vs, vs_act(n));
    chk("b_blank", b_bl, bl_exp(n));
    chk("c_hcount", c_h, h);
    chk("c_vcount", c_v, v);
    chk("c_frame_start", c_fs, c_ls && (v == 0));
    if (n >= 3) begin
      chk("c_blank", c_bl, bl_exp(n - 3));
      chk("c_hsync", c_hs, !hs_act(n - 3));
      chk("c_vsync", c_vs, !vs_act(n - 3));
    end else begin
      chk("c_blank_init", c_bl, 1);
      chk("c_hsync_init", c_hs, 1);
      chk("c_vsync_init", c_vs, 1);
    end
    chk("e_frame", e_fc, (n / 128) % 4);
  endtask

  initial begin
    // rst en  h  v  hs vs bl ls fs fc
    tbl[0]  = '{1'b1, 1'b0,  0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    tbl[1]  = '{1'b0, 1'b1,  1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b0, 1'b1,  2, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b0, 1'b1,  3, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b0, 1'b0,  3, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b0, 1'b0,  3, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[6]  = '{1'b0, 1'b1,  4, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[7]  = '{1'b0, 1'b1,  5, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[8]  = '{1'b0, 1'b1,  6, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[9]  = '{1'b0, 1'b1,  7, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[10] = '{1'b0, 1'b1,  8, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[11] = '{1'b0, 1'b1,  9, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[12] = '{1'b0, 1'b1, 10, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[13] = '{1'b0, 1'b1, 11, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[14] = '{1'b0, 1'b1, 12, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[15] = '{1'b0, 1'b0, 12, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[16] = '{1'b0, 1'b1, 13, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[17] = '{1'b0, 1'b1, 14, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[18] = '{1'b0, 1'b1, 15, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[19] = '{1'b0, 1'b1,  0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    tbl[20] = '{1'b0, 1'b1,  1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[21] = '{1'b1, 1'b1,  0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0};

    for (int i = 0; i < 22; i++) begin
      tick(tbl[i].rst, tbl[i].en);
      chk($sformatf("vec%0d_hcount", i), a_h, tbl[i].h);
      chk($sformatf("vec%0d_vcount", i), a_v, tbl[i].v);
      chk($sformatf("vec%0d_hsync", i), a_hs, tbl[i].hs);
      chk($sformatf("vec%0d_vsync", i), a_vs, tbl[i].vs);
      chk($sformatf("vec%0d_blank", i), a_bl, tbl[i].bl);
      chk($sformatf("vec%0d_line_start", i), a_ls, tbl[i].ls);
      chk($sformatf("vec%0d_frame_start", i), a_fs, tbl[i].fs);
      chk($sformatf("vec%0d_frame", i), a_fc, tbl[i].fc);
      chk($sformatf("vec%0d_pos_hsync", i), b_hs, !tbl[i].hs);
      chk($sformatf("vec%0d_dly_hcount", i), c_h, tbl[i].h);
    end

    // Two full frames with enable held high, from a fresh reset.
    tick(1'b1, 1'b0);
    check_model();
    repeat (256) begin
      tick(1'b0, 1'b1);
      check_model();
    end

    // Enable pattern 1,0,0,1 repeated: outputs hold on low cycles.
    for (int k = 0; k < 240; k++) begin
      tick(1'b0, (k % 4 == 0) || (k % 4 == 3));
      check_model();
    end

    // Walk to pixel (6,5), drop enable, then reset mid-frame.
    for (int k = 0; k < 200 && (n % 128) != 86; k++) begin
      tick(1'b0, 1'b1);
      check_model();
    end
    tick(1'b0, 1'b0);
    chk("pre_reset_hcount", a_h, 6);
    chk("pre_reset_vcount", a_v, 5);
    tick(1'b1, 1'b0);
    check_model();
    chk("mid_reset_c_blank", c_bl, 1);

    // Five frames: the 2-bit frame counter must read 0,1,2,3,0 at frame starts.
    tick(1'b1, 1'b0);
    fc_seq[0] = e_fc;
    n_seq = 1;
    repeat (5 * 128) begin
      tick(1'b0, 1'b1);
      check_model();
      if (e_fs && n_seq < 8) begin
        fc_seq[n_seq] = e_fc;
        n_seq++;
      end
    end
    chk("fc_seq_len", n_seq, 6);
    chk("fc_seq0", fc_seq[0], 0);
    chk("fc_seq1", fc_seq[1], 1);
    chk("fc_seq2", fc_seq[2], 2);
    chk("fc_seq3", fc_seq[3], 3);
    chk("fc_seq4", fc_seq[4], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
